// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter
// Brief   : Shares one memory port between instruction fetch and data access,
//           data first, with a burst cap so fetch cannot starve.
// Revision: 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int PC_WIDTH       = 32,
  parameter int MEM_LATENCY    = 2,
  parameter int DATA_BURST_MAX = 4
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_InstReq,
  input  logic [PC_WIDTH-1:0]   i_InstAddr,
  output logic                  o_InstAck,
  output logic [31:0]           o_InstData,
  input  logic                  i_DataReq,
  input  logic                  i_DataWrEnable,
  input  logic [ADDR_WIDTH-1:0] i_DataAddr,
  input  logic [DATA_WIDTH-1:0] i_DataWrData,
  output logic                  o_DataAck,
  output logic [DATA_WIDTH-1:0] o_DataRdData,
  output logic [ADDR_WIDTH-1:0] o_MemAddr,
  output logic                  o_MemWrEnable,
  output logic [DATA_WIDTH-1:0] o_MemWrData,
  input  logic [DATA_WIDTH-1:0] i_MemRdData,
  output logic                  o_Busy
);

  localparam logic [3:0] LAT_LOAD  = 4'(MEM_LATENCY - 1);
  localparam logic [3:0] BURST_MAX = 4'(DATA_BURST_MAX);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

  state_t                  state_q,      state_d;
  logic                    owner_data_q, owner_data_d;
  logic [ADDR_WIDTH-1:0]   addr_q,       addr_d;
  logic                    we_q,         we_d;
  logic [DATA_WIDTH-1:0]   wdata_q,      wdata_d;
  logic [3:0]              lat_q,        lat_d;
  logic [3:0]              burst_q,      burst_d;
  logic [31:0]             inst_data_q,  inst_data_d;
  logic [DATA_WIDTH-1:0]   data_rd_q,    data_rd_d;
  logic                    inst_wins;

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      state_q      <= ST_IDLE;
      owner_data_q <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      lat_q        <= '0;
      burst_q      <= '0;
      inst_data_q  <= '0;
      data_rd_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_data_q <= owner_data_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      lat_q        <= lat_d;
      burst_q      <= burst_d;
      inst_data_q  <= inst_data_d;
      data_rd_q    <= data_rd_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_data_d = owner_data_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    lat_d        = lat_q;
    burst_d      = burst_q;
    inst_data_d  = inst_data_q;
    data_rd_d    = data_rd_q;
    // Fetch only loses a tie while the data streak is below the cap.
    inst_wins    = i_InstReq && (!i_DataReq || (burst_q == BURST_MAX));

    unique case (state_q)
      ST_IDLE: begin
        if (i_InstReq || i_DataReq) begin
          state_d = ST_ACCESS;
          if (inst_wins) begin
            owner_data_d = 1'b0;
            addr_d       = ADDR_WIDTH'(i_InstAddr);
            we_d         = 1'b0;
            wdata_d      = '0;
            lat_d        = LAT_LOAD;
            burst_d      = '0;
          end else begin
            owner_data_d = 1'b1;
            addr_d       = i_DataAddr;
            we_d         = i_DataWrEnable;
            wdata_d      = i_DataWrData;
            lat_d        = i_DataWrEnable ? 4'd0 : LAT_LOAD;
            if (!i_InstReq) begin
              burst_d = '0;
            end else if (burst_q != BURST_MAX) begin
              burst_d = burst_q + 4'd1;
            end
          end
        end
      end
      ST_ACCESS: begin
        if (lat_q == 4'd0) begin
          state_d = ST_ACK;
          if (!we_q) begin
            if (owner_data_q) begin
              data_rd_d = i_MemRdData;
            end else begin
              inst_data_d = i_MemRdData[31:0];
            end
          end
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bus outputs decode from state only, so reset clears them without a clock.
  assign o_Busy        = (state_q != ST_IDLE);
  assign o_MemAddr     = (state_q == ST_ACCESS) ? addr_q : '0;
  assign o_MemWrEnable = (state_q == ST_ACCESS) && we_q;
  assign o_MemWrData   = o_MemWrEnable ? wdata_q : '0;
  assign o_InstAck     = (state_q == ST_ACK) && !owner_data_q;
  assign o_DataAck     = (state_q == ST_ACK) && owner_data_q;
  assign o_InstData    = inst_data_q;
  assign o_DataRdData  = data_rd_q;

endmodule
`default_nettype wire
